// File: rtl/snake_vga_pkg.sv
// Shared definitions for the Snake display path.
// Holds tile codes, the RRRGGGBB colour constants, playfield geometry defaults,
// the renderer state encoding and small helpers for tile-map addressing.
package snake_vga_pkg;

  // Playfield geometry defaults
  localparam int unsigned GridW     = 40;
  localparam int unsigned GridH     = 30;
  localparam int unsigned TileShift = 4;
  localparam int unsigned HVisible  = 640;
  localparam int unsigned VVisible  = 480;

  // Tile map addressing: 1200 entries need 11 address bits
  localparam int unsigned TileAddrW = 11;
  localparam int unsigned TileW     = 2;

  typedef enum logic [TileW-1:0] {
    TileEmpty = 2'd0,
    TileSnake = 2'd1,
    TileFood  = 2'd2,
    TileWall  = 2'd3
  } tile_e;

  // Colours, RRRGGGBB
  localparam logic [7:0] ColEmpty = 8'b000_000_00;
  localparam logic [7:0] ColSnake = 8'b000_111_00;
  localparam logic [7:0] ColFood  = 8'b111_000_00;
  localparam logic [7:0] ColWall  = 8'b111_111_11;

  typedef enum logic [0:0] {
    StClear = 1'b0,
    StRun   = 1'b1
  } state_e;

  function automatic logic [7:0] tile_colour(input tile_e tile);
    logic [7:0] col;
    unique case (tile)
      TileEmpty: col = ColEmpty;
      TileSnake: col = ColSnake;
      TileFood:  col = ColFood;
      TileWall:  col = ColWall;
      default:   col = ColEmpty;
    endcase
    return col;
  endfunction

  // Start address of a tile row: row * 40 built from two shifts, no multiplier.
  // Only valid for a 40-tile-wide playfield.
  function automatic logic [TileAddrW-1:0] row_base(input logic [TileAddrW-1:0] row);
    return (row << 5) + (row << 3);
  endfunction

endpackage

// File: rtl/snake_tile_ram.sv
// Tile map storage for the Snake playfield.
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
// The read port is read-first: a same-cycle write to the read address returns
// the old contents. Contents are not reset.
//
// Ports:
//   clk_i    pixel clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data (tile code)
//   raddr_i  read address, sampled every cycle
//   rdata_o  registered read data, valid the cycle after raddr_i
module snake_tile_ram #(
  parameter int unsigned Depth = 1200,
  parameter int unsigned AddrW = 11,
  parameter int unsigned DataW = 2
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/snake_tile_renderer.sv
// Pixel-colour source for the Snake VGA path.
// Holds the playfield tile map, initialises it (walls on the border, empty
// inside) after reset or on request, accepts tile writes from the game logic,
// and converts the VGA stage's pixel coordinates into an RRRGGGBB colour with a
// fixed two-cycle latency. Also pulses FRAME_TICK once per frame when the line
// counter enters vertical blank.
//
// Ports:
//   CLK, RESETn        pixel clock, asynchronous active-low reset
//   XCoord, YCoord     pixel coordinates from the VGA timing stage
//   WR_VALID/WR_READY  tile write handshake; WR_X, WR_Y, WR_TILE carry the write
//   CLEAR_REQ          one-cycle request to reinitialise the playfield
//   BUSY               high while initialisation runs
//   PIXEL_OUT          colour for the coordinates presented two cycles earlier
//   FRAME_TICK         one-cycle pulse at the start of vertical blank
module snake_tile_renderer
  import snake_vga_pkg::*;
#(
  parameter int unsigned GRID_W     = GridW,
  parameter int unsigned GRID_H     = GridH,
  parameter int unsigned TILE_SHIFT = TileShift,
  parameter int unsigned H_VISIBLE  = HVisible,
  parameter int unsigned V_VISIBLE  = VVisible
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [10:0] XCoord,
  input  logic [10:0] YCoord,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic [5:0]  WR_X,
  input  logic [4:0]  WR_Y,
  input  logic [1:0]  WR_TILE,
  input  logic        CLEAR_REQ,
  output logic        BUSY,
  output logic [7:0]  PIXEL_OUT,
  output logic        FRAME_TICK
);

  localparam int unsigned NumTiles = GRID_W * GRID_H;
  localparam int unsigned AddrW    = TileAddrW;

  // ---------------------------------------------------------------------------
  // State and clear walk
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
  // Column/row of the clear address tracked alongside the counter so the
  // border test needs no divider.
  logic [5:0]       clr_x_q, clr_x_d;
  logic [4:0]       clr_y_q, clr_y_d;

  logic             clr_last;
  logic             clr_border;

  assign clr_last   = (clr_cnt_q == AddrW'(NumTiles - 1));
  assign clr_border = (clr_x_q == '0) || (clr_x_q == 6'(GRID_W - 1)) ||
                      (clr_y_q == '0) || (clr_y_q == 5'(GRID_H - 1));

  // ---------------------------------------------------------------------------
  // Write port
  // ---------------------------------------------------------------------------
  logic             wr_in_range;
  logic [AddrW-1:0] wr_addr;

  logic             ram_we;
  logic [AddrW-1:0] ram_waddr;
  tile_e            ram_wdata;

  assign wr_in_range = (WR_X < 6'(GRID_W)) && (WR_Y < 5'(GRID_H));
  assign wr_addr     = row_base(AddrW'(WR_Y)) + AddrW'(WR_X);

  assign BUSY     = (state_q == StClear);
  assign WR_READY = (state_q == StRun);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_x_d   = clr_x_q;
    clr_y_d   = clr_y_q;
    ram_we    = 1'b0;
    ram_waddr = clr_cnt_q;
    ram_wdata = TileEmpty;

    unique case (state_q)
      StClear: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = clr_border ? TileWall : TileEmpty;
        if (clr_last) begin
          state_d   = StRun;
          clr_cnt_d = '0;
          clr_x_d   = '0;
          clr_y_d   = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_x_q == 6'(GRID_W - 1)) begin
            clr_x_d = '0;
            clr_y_d = clr_y_q + 1'b1;
          end else begin
            clr_x_d = clr_x_q + 1'b1;
          end
        end
      end

      StRun: begin
        // Out-of-range writes still complete the handshake but leave the map alone.
        if (WR_VALID && wr_in_range) begin
          ram_we    = 1'b1;
          ram_waddr = wr_addr;
          ram_wdata = tile_e'(WR_TILE);
        end
        if (CLEAR_REQ) begin
          state_d   = StClear;
          clr_cnt_d = '0;
          clr_x_d   = '0;
          clr_y_d   = '0;
        end
      end

      default: begin
        state_d   = StClear;
        clr_cnt_d = '0;
        clr_x_d   = '0;
        clr_y_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic             rd_visible;
  logic [10:0]      tile_x;
  logic [10:0]      tile_y;
  logic [AddrW-1:0] rd_addr;
  logic [TileW-1:0] ram_rdata;

  assign rd_visible = (XCoord < 11'(H_VISIBLE)) && (YCoord < 11'(V_VISIBLE));
  assign tile_x     = XCoord >> TILE_SHIFT;
  assign tile_y     = YCoord >> TILE_SHIFT;
  // Off-screen coordinates would index past the map; park the read at 0.
  assign rd_addr    = rd_visible ? (row_base(AddrW'(tile_y)) + AddrW'(tile_x)) : '0;

  snake_tile_ram #(
    .Depth (NumTiles),
    .AddrW (AddrW),
    .DataW (TileW)
  ) u_tile_ram (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  // Stage 1 flags travel alongside the RAM read; stage 2 is the colour register.
  logic       vis_q;
  logic       busy_q;
  logic [7:0] pixel_q, pixel_d;

  assign pixel_d = (vis_q && !busy_q) ? tile_colour(tile_e'(ram_rdata)) : ColEmpty;

  // ---------------------------------------------------------------------------
  // Frame tick: rising edge of "line counter at first blank line"
  // ---------------------------------------------------------------------------
  logic at_vblank;
  logic at_vblank_q;
  logic tick_q, tick_d;

  assign at_vblank = (YCoord == 11'(V_VISIBLE));
  assign tick_d    = at_vblank && !at_vblank_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= StClear;
      clr_cnt_q   <= '0;
      clr_x_q     <= '0;
      clr_y_q     <= '0;
      vis_q       <= 1'b0;
      busy_q      <= 1'b0;
      pixel_q     <= '0;
      at_vblank_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_x_q     <= clr_x_d;
      clr_y_q     <= clr_y_d;
      vis_q       <= rd_visible;
      busy_q      <= BUSY;
      pixel_q     <= pixel_d;
      at_vblank_q <= at_vblank;
      tick_q      <= tick_d;
    end
  end

  assign PIXEL_OUT  = pixel_q;
  assign FRAME_TICK = tick_q;

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Self-checking bench for snake_tile_renderer: directed scenarios followed by
// randomized traffic, all compared against a tile-map reference model.
module tb_snake_tile_renderer;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [10:0] XCoord = '0;
  logic [10:0] YCoord = '0;
  logic        WR_VALID = 1'b0;
  logic        WR_READY;
  logic [5:0]  WR_X = '0;
  logic [4:0]  WR_Y = '0;
  logic [1:0]  WR_TILE = '0;
  logic        CLEAR_REQ = 1'b0;
  logic        BUSY;
  logic [7:0]  PIXEL_OUT;
  logic        FRAME_TICK;

  always #20 CLK = ~CLK;

  snake_tile_renderer dut (
    .CLK        (CLK),
    .RESETn     (RESETn),
    .XCoord     (XCoord),
    .YCoord     (YCoord),
    .WR_VALID   (WR_VALID),
    .WR_READY   (WR_READY),
    .WR_X       (WR_X),
    .WR_Y       (WR_Y),
    .WR_TILE    (WR_TILE),
    .CLEAR_REQ  (CLEAR_REQ),
    .BUSY       (BUSY),
    .PIXEL_OUT  (PIXEL_OUT),
    .FRAME_TICK (FRAME_TICK)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the playfield as a 2-D array of tile codes
  int tiles [40][30];
  bit m_busy;
  int m_clear_left;
  int prev_y;
  int pipe [$];

  function automatic int colour_of(input int t);
    case (t)
      1:       return 'h1C;
      2:       return 'hE0;
      3:       return 'hFF;
      default: return 'h00;
    endcase
  endfunction

  function automatic int expect_pixel(input int x, input int y);
    if (m_busy) return 0;
    if (x >= 640 || y >= 480) return 0;
    return colour_of(tiles[x / 16][y / 16]);
  endfunction

  task automatic fill_border();
    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 30; y++)
        tiles[x][y] = (x == 0 || x == 39 || y == 0 || y == 29) ? 3 : 0;
  endtask

  task automatic model_reset();
    m_busy       = 1'b1;
    m_clear_left = 1200;
    prev_y       = 0;
    pipe.delete();
    pipe.push_back(0);
  endtask

  // One clock: predict from the current inputs, advance, compare.
  task automatic step();
    int  x, y, ep;
    bit  et;
    x  = int'(XCoord);
    y  = int'(YCoord);
    ep = expect_pixel(x, y);
    pipe.push_back(ep);
    et     = (y == 480) && (prev_y != 480);
    prev_y = y;
    if (m_busy) begin
      m_clear_left--;
      if (m_clear_left == 0) begin
        fill_border();
        m_busy = 1'b0;
      end
    end else begin
      if (WR_VALID && int'(WR_X) < 40 && int'(WR_Y) < 30)
        tiles[int'(WR_X)][int'(WR_Y)] = int'(WR_TILE);
      if (CLEAR_REQ) begin
        m_busy       = 1'b1;
        m_clear_left = 1200;
      end
    end
    @(posedge CLK);
    #1;
    check_eq("pixel", 32'(PIXEL_OUT), 32'(pipe.pop_front()));
    check_eq("tick", 32'(FRAME_TICK), 32'(et));
    check_eq("busy", 32'(BUSY), 32'(m_busy));
    check_eq("ready", 32'(WR_READY), 32'(!m_busy));
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    #1;
    check_eq("rst_pixel", 32'(PIXEL_OUT), 32'h0);
    check_eq("rst_tick", 32'(FRAME_TICK), 32'h0);
    check_eq("rst_busy", 32'(BUSY), 32'h1);
    check_eq("rst_ready", 32'(WR_READY), 32'h0);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    model_reset();
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (BUSY === 1'b1 && n < 1300) begin
      step();
      n++;
    end
    check_eq(tag, 32'(n), 32'd1200);
  endtask

  task automatic probe(input string tag, input int x, input int y, input int exp);
    XCoord = 11'(x);
    YCoord = 11'(y);
    step();
    step();
    check_eq(tag, 32'(PIXEL_OUT), 32'(exp));
  endtask

  task automatic write_tile(input int x, input int y, input int t);
    WR_X     = 6'(x);
    WR_Y     = 5'(y);
    WR_TILE  = 2'(t);
    WR_VALID = 1'b1;
    step();
    WR_VALID = 1'b0;
  endtask

  initial begin
    int ticks, tick_pos, nonzero, last_wx, last_wy;

    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 30; y++)
        tiles[x][y] = 0;

    // Power-on reset and first initialisation
    do_reset();
    wait_clear("clear_len_boot");
    probe("corner_wall", 0, 0, 'hFF);
    probe("centre_empty", 320, 240, 'h00);

    // Tile writes and exact latency
    write_tile(5, 7, 1);
    write_tile(6, 7, 2);
    probe("snake_lo", 80, 112, 'h1C);
    probe("snake_hi", 95, 127, 'h1C);
    probe("food", 96, 112, 'hE0);
    XCoord = 11'd320;
    YCoord = 11'd240;
    step();
    step();
    XCoord = 11'd80;
    YCoord = 11'd112;
    step();
    check_eq("lat_one_cycle", 32'(PIXEL_OUT), 32'h00);
    step();
    check_eq("lat_two_cycle", 32'(PIXEL_OUT), 32'h1C);

    // Out-of-range writes: accepted, map unchanged
    WR_X = 6'd40; WR_Y = 5'd3; WR_TILE = 2'd1; WR_VALID = 1'b1;
    #1;
    check_eq("oor_ready", 32'(WR_READY), 32'h1);
    step();
    write_tile(2, 30, 2);
    probe("oor_wrap_row4", 0, 64, 'hFF);
    probe("oor_row3_in", 16, 48, 'h00);
    probe("oor_bottom", 32, 464, 'hFF);

    // Frame tick sweep and off-screen coordinates
    XCoord = 11'd100;
    ticks = 0;
    tick_pos = -1;
    for (int i = 0; i < 6; i++) begin
      YCoord = 11'((i < 4) ? 478 + i : 481);
      step();
      if (FRAME_TICK === 1'b1) begin
        ticks++;
        tick_pos = i;
      end
    end
    check_eq("tick_count", 32'(ticks), 32'd1);
    check_eq("tick_pos", 32'(tick_pos), 32'd2);
    probe("offscreen_x", 700, 100, 'h00);
    probe("offscreen_y", 100, 500, 'h00);

    // Clear request wipes game tiles
    write_tile(10, 10, 1);
    probe("pre_clear_snake", 160, 160, 'h1C);
    XCoord = 11'd0;
    YCoord = 11'd0;
    CLEAR_REQ = 1'b1;
    step();
    CLEAR_REQ = 1'b0;
    nonzero = 0;
    for (int i = 0; i < 1199; i++) begin
      step();
      if (i >= 1 && PIXEL_OUT !== 8'h00) nonzero++;
    end
    check_eq("clear_dark", 32'(nonzero), 32'd0);
    check_eq("clear_busy_end", 32'(BUSY), 32'h1);
    step();
    check_eq("clear_done", 32'(BUSY), 32'h0);
    probe("post_clear_tile", 160, 160, 'h00);
    probe("post_clear_wall", 639, 479, 'hFF);

    // Reset during RUN while a wall pixel is on the output
    probe("run_pixel", 0, 0, 'hFF);
    do_reset();
    wait_clear("clear_len_run_rst");

    // Reset in the middle of a clear
    CLEAR_REQ = 1'b1;
    step();
    CLEAR_REQ = 1'b0;
    for (int i = 0; i < 600; i++) step();
    do_reset();
    wait_clear("clear_len_mid_rst");
    probe("mid_rst_wall", 0, 240, 'hFF);

    // Randomized traffic
    last_wx = 5;
    last_wy = 7;
    for (int i = 0; i < 6000; i++) begin
      WR_VALID = ($urandom_range(0, 1) == 1);
      WR_X     = 6'($urandom_range(0, 41));
      WR_Y     = 5'($urandom_range(0, 31));
      WR_TILE  = 2'($urandom_range(0, 3));
      if (WR_VALID && WR_X < 6'd40 && WR_Y < 5'd30) begin
        last_wx = int'(WR_X);
        last_wy = int'(WR_Y);
      end
      if ($urandom_range(0, 1) == 1) begin
        XCoord = 11'(last_wx * 16 + int'($urandom_range(0, 15)));
        YCoord = 11'(last_wy * 16 + int'($urandom_range(0, 15)));
      end else begin
        XCoord = 11'($urandom_range(0, 799));
        YCoord = 11'($urandom_range(0, 524));
      end
      CLEAR_REQ = ($urandom_range(0, 2999) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
